// File: rtl/mem_arbiter_pkg.sv
// Shared sizes, encodings and the latched-access payload for mem_arbiter.
package mem_arbiter_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned OP_W   = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_IO_WAIT} state_t;
  typedef enum logic {SRC_IF, SRC_LS} src_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [OP_W-1:0] OP_FETCH = {1'b0, SIZE_W};
  localparam logic [1:0] IO_REGION = 2'b11;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [OP_W-1:0]   op;
    logic [CNT_W-1:0]  len;
    src_t              src;
  } access_t;

  // Byte count for a funct3 size code
  function automatic logic [CNT_W-1:0] size_len(input logic [1:0] size);
    case (size)
      SIZE_B:  return CNT_W'(1);
      SIZE_H:  return CNT_W'(2);
      default: return CNT_W'(4);
    endcase
  endfunction
endpackage

// File: rtl/mem_arbiter_load_ext.sv
// Sign/zero extension of a raw little-endian load value by funct3.
module mem_load_ext
  import mem_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] raw,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] value
);
  always_comb begin
    value = raw;
    case (op[1:0])
      SIZE_B:  value = op[2] ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      SIZE_H:  value = op[2] ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: value = raw;
    endcase
  end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin IF/LSB arbiter serialising accesses onto a byte-wide RAM/IO bus.
// Optional MEM_ARB_IO_STALL_EN: IO-region stores wait while io_buffer_full is high.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rob_clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  output logic              ls_welcome,
  input  logic              ls_req,
  input  logic [OP_W-1:0]   ls_op,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  input  logic [BYTE_W-1:0] mem_din,
  output logic [BYTE_W-1:0] mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);
  state_t            state;
  src_t              last_grant;
  access_t           acc;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rbuf;

  logic              if_elig, ls_elig, grant_valid;
  src_t              grant_src;
  logic [CNT_W-1:0]  next_idx;
  logic [ADDR_W-1:0] next_addr;
  logic [BYTE_W-1:0] next_byte;
  logic [DATA_W-1:0] raw_c;
  logic [DATA_W-1:0] ext_c;

`ifdef MEM_ARB_IO_STALL_EN
  logic io;
  logic ls_io;
  assign ls_io = (ls_addr[17:16] == IO_REGION);
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
`endif

  // No grant while a done pulse is out, so the next grant is the cycle after done
  always_comb begin
    if_elig     = if_req && !if_done;
    ls_elig     = ls_req && !ls_done;
    grant_valid = (state == ST_IDLE) && !if_done && !ls_done && (if_elig || ls_elig);
    grant_src   = (ls_elig && (!if_elig || last_grant == SRC_IF)) ? SRC_LS : SRC_IF;
  end

  assign next_idx   = cnt + CNT_W'(1);
  assign next_addr  = acc.addr + ADDR_W'(next_idx);
  assign next_byte  = acc.wdata[{next_idx[1:0], 3'b000} +: BYTE_W];
  assign ls_welcome = (state == ST_IDLE) && !ls_done && !if_done;

  // Byte on mem_din belongs to the address presented in the previous RD cycle
  always_comb begin
    raw_c = rbuf;
    if (cnt != '0) raw_c[{2'(cnt - CNT_W'(1)), 3'b000} +: BYTE_W] = mem_din;
  end

  mem_load_ext u_ext (
    .raw   (raw_c),
    .op    (acc.op),
    .value (ext_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= SRC_IF;
      acc        <= '0;
      cnt        <= '0;
      rbuf       <= '0;
      mem_a      <= '0;
      mem_dout   <= '0;
      mem_wr     <= 1'b0;
      if_data    <= '0;
      ls_rdata   <= '0;
      if_done    <= 1'b0;
      ls_done    <= 1'b0;
`ifdef MEM_ARB_IO_STALL_EN
      io         <= 1'b0;
`endif
    end else if (rdy) begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rob_clear) begin
            last_grant <= SRC_IF;
          end else if (grant_valid) begin
            cnt        <= '0;
            rbuf       <= '0;
            last_grant <= grant_src;
            acc.src    <= grant_src;
            if (grant_src == SRC_LS) begin
              acc.addr  <= ls_addr;
              acc.wdata <= ls_wdata;
              acc.op    <= ls_op;
              acc.len   <= size_len(ls_op[1:0]);
              mem_a     <= ls_addr;
              mem_dout  <= ls_wdata[BYTE_W-1:0];
              if (ls_we) begin
`ifdef MEM_ARB_IO_STALL_EN
                io <= ls_io;
                if (ls_io && io_buffer_full) begin
                  state <= ST_IO_WAIT;
                end else begin
                  state  <= ST_WR;
                  mem_wr <= 1'b1;
                end
`else
                state  <= ST_WR;
                mem_wr <= 1'b1;
`endif
              end else begin
                state <= ST_RD;
              end
            end else begin
              acc.addr  <= if_addr;
              acc.wdata <= '0;
              acc.op    <= OP_FETCH;
              acc.len   <= CNT_W'(4);
              mem_a     <= if_addr;
              state     <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (rob_clear) begin
            // Flushed load/fetch: drop everything, no done pulse
            state      <= ST_IDLE;
            cnt        <= '0;
            last_grant <= SRC_IF;
            rbuf       <= '0;
            mem_a      <= '0;
            mem_dout   <= '0;
            if_data    <= '0;
            ls_rdata   <= '0;
          end else if (cnt == acc.len) begin
            state <= ST_IDLE;
            cnt   <= '0;
            rbuf  <= raw_c;
            if (acc.src == SRC_IF) begin
              if_done <= 1'b1;
              if_data <= raw_c;
            end else begin
              ls_done  <= 1'b1;
              ls_rdata <= ext_c;
            end
          end else begin
            rbuf <= raw_c;
            cnt  <= next_idx;
            if (next_idx < acc.len) mem_a <= next_addr;
          end
        end
        ST_WR: begin
          if (next_idx < acc.len) begin
            cnt      <= next_idx;
            mem_a    <= next_addr;
            mem_dout <= next_byte;
`ifdef MEM_ARB_IO_STALL_EN
            if (io && io_buffer_full) begin
              mem_wr <= 1'b0;
              state  <= ST_IO_WAIT;
            end
`endif
          end else begin
            state    <= ST_IDLE;
            cnt      <= '0;
            mem_wr   <= 1'b0;
            ls_done  <= 1'b1;
            ls_rdata <= '0;
          end
        end
`ifdef MEM_ARB_IO_STALL_EN
        ST_IO_WAIT: begin
          if (!io_buffer_full) begin
            mem_wr <= 1'b1;
            state  <= ST_WR;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a byte RAM model and write log.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst, rdy, rob_clear;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_data;
  logic        ls_welcome, ls_req, ls_we, ls_done;
  logic [2:0]  ls_op;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  logic [7:0]  mem [0:1023];
  logic [31:0] wlog_a[$];
  logic [7:0]  wlog_d[$];
  int          wlog_c[$];
  int          cyc = 0;
  int          t_issue;
  int          n_checks = 0;
  int          n_pass = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_welcome(ls_welcome), .ls_req(ls_req), .ls_op(ls_op), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM: read data one cycle after the address; writes are only logged
  always @(posedge clk) begin
    mem_din <= mem[mem_a[9:0]];
    if (mem_wr) begin
      wlog_a.push_back(mem_a);
      wlog_d.push_back(mem_dout);
      wlog_c.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One access from T; clr_k / frz_lo..frz_hi / io_k are cycle offsets from T
  task automatic access(input string tag, input bit is_if, input bit we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wd, input int clr_k,
                        input int frz_lo, input int frz_hi, input int io_k,
                        input int exp_lat, input logic [31:0] exp_data);
    int lat;
    logic [31:0] got;
    lat = 0;
    got = '0;
    @(negedge clk);
    t_issue = cyc;
    io_buffer_full = (io_k > 0);
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      ls_req = 1'b1; ls_we = we; ls_op = op; ls_addr = addr; ls_wdata = wd;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (is_if ? if_done : ls_done) begin
        lat = k;
        got = is_if ? if_data : ls_rdata;
      end
      if (clr_k != 0 && k == clr_k + 1 && !we) check({tag, " welcome"}, 32'(ls_welcome), 32'd1);
      if (lat != 0) break;
      rdy = !(k >= frz_lo && k <= frz_hi);
      rob_clear = (k == clr_k);
      io_buffer_full = (k < io_k);
      if (k == clr_k && !we) begin
        if_req = 1'b0; ls_req = 1'b0;
      end
    end
    if_req = 1'b0; ls_req = 1'b0; rdy = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    if (exp_lat != 0) check({tag, " data"}, got, exp_data);
  endtask

  task automatic check_writes(input string tag, input int n0, input logic [31:0] base,
                              input logic [31:0] data, input int nbytes, input int first_cyc);
    logic [31:0] sh;
    check({tag, " nwrites"}, 32'(wlog_a.size() - n0), 32'(nbytes));
    for (int i = 0; i < nbytes; i++) begin
      if (n0 + i < wlog_a.size()) begin
        sh = data >> (8 * i);
        check({tag, " waddr"}, wlog_a[n0+i], base + 32'(i));
        check({tag, " wbyte"}, {24'd0, wlog_d[n0+i]}, {24'd0, sh[7:0]});
        check({tag, " wcycle"}, 32'(wlog_c[n0+i]), 32'(first_cyc + i));
      end
    end
  endtask

  initial begin
    int n0, ls_k, if_k, ls_cnt;
    logic [31:0] ls_val, if_val;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h11; mem[10'h101] = 8'h22; mem[10'h102] = 8'h33; mem[10'h103] = 8'h44;
    mem[10'h104] = 8'h55; mem[10'h105] = 8'h66; mem[10'h106] = 8'h77; mem[10'h107] = 8'h88;
    mem[10'h008] = 8'h80; mem[10'h00A] = 8'h34; mem[10'h00B] = 8'h92;
    mem[10'h3FE] = 8'hAA; mem[10'h3FF] = 8'hBB; mem[10'h000] = 8'hCC; mem[10'h001] = 8'hDD;
    mem[10'h040] = 8'h05; mem[10'h200] = 8'hF0; mem[10'h201] = 8'hFF;

    rst = 1'b1; rdy = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_op = '0; ls_addr = '0; ls_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst mem_wr", 32'(mem_wr), 32'd0);
    check("rst mem_a", mem_a, 32'd0);
    check("rst dones", {30'd0, if_done, ls_done}, 32'd0);
    check("rst welcome", 32'(ls_welcome), 32'd1);
    check("rst if_data", if_data, 32'd0);
    check("rst ls_rdata", ls_rdata, 32'd0);

    access("fetch", 1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 0, 0, 0, 0, 6, 32'h44332211);
    access("lb", 1'b0, 1'b0, 3'b000, 32'h8, 32'd0, 0, 0, 0, 0, 3, 32'hFFFFFF80);
    access("lbu", 1'b0, 1'b0, 3'b100, 32'h8, 32'd0, 0, 0, 0, 0, 3, 32'h00000080);
    access("lh", 1'b0, 1'b0, 3'b001, 32'hA, 32'd0, 0, 0, 0, 0, 4, 32'hFFFF9234);
    access("lhu", 1'b0, 1'b0, 3'b101, 32'hA, 32'd0, 0, 0, 0, 0, 4, 32'h00009234);
    access("lw wrap", 1'b0, 1'b0, 3'b010, 32'hFFFFFFFE, 32'd0, 0, 0, 0, 0, 6, 32'hDDCCBBAA);

    n0 = wlog_a.size();
    access("sw", 1'b0, 1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 0, 0, 0, 0, 5, 32'd0);
    check_writes("sw", n0, 32'h20, 32'hDEADBEEF, 4, t_issue + 1);

    n0 = wlog_a.size();
`ifdef MEM_ARB_IO_STALL_EN
    access("sb io", 1'b0, 1'b1, 3'b000, 32'h30000, 32'h5A, 0, 0, 0, 3, 5, 32'd0);
    check_writes("sb io", n0, 32'h30000, 32'h5A, 1, t_issue + 4);
`else
    access("sb io", 1'b0, 1'b1, 3'b000, 32'h30000, 32'h5A, 0, 0, 0, 3, 2, 32'd0);
    check_writes("sb io", n0, 32'h30000, 32'h5A, 1, t_issue + 1);
`endif

    access("lw flush", 1'b0, 1'b0, 3'b010, 32'h100, 32'd0, 3, 0, 0, 0, 0, 32'd0);

    n0 = wlog_a.size();
    access("sh flush", 1'b0, 1'b1, 3'b001, 32'h50, 32'h1234CAFE, 1, 0, 0, 0, 3, 32'd0);
    check_writes("sh flush", n0, 32'h50, 32'h1234CAFE, 2, t_issue + 1);

    access("lh frozen", 1'b0, 1'b0, 3'b001, 32'h200, 32'd0, 0, 1, 2, 0, 6, 32'hFFFFFFF0);

    // Both requesters with last-grant = IF after reset: LSB first, then fetch
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h104;
    ls_req = 1'b1; ls_we = 1'b0; ls_op = 3'b000; ls_addr = 32'h40;
    ls_k = 0; if_k = 0; ls_cnt = 0; ls_val = '0; if_val = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ls_done) begin
        ls_cnt++;
        if (ls_k == 0) begin ls_k = k; ls_val = ls_rdata; end
        ls_req = 1'b0;
      end
      if (if_done && if_k == 0) begin
        if_k = k; if_val = if_data; if_req = 1'b0;
      end
    end
    check("arb ls latency", 32'(ls_k), 32'd3);
    check("arb ls data", ls_val, 32'h00000005);
    check("arb if latency", 32'(if_k), 32'd10);
    check("arb if data", if_val, 32'h88776655);
    check("arb ls pulses", 32'(ls_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
